cpu_mem_responder: RTL

- Memory-side responder for the CPU's data and instruction buses.
- Serves combinational instruction fetch and data reads, and commits data writes.
- Owns a program-loader handshake that fills instruction memory while the CPU is held in reset, then releases the CPU to run.
- Sits between the testbench/host loader and the CPU core; drives the CPU's active-high reset.

---
 rtl/cpu_mem_responder.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/cpu_mem_responder.sv
// rtl/cpu_mem_responder.sv - CPU instruction/data memory responder with program loader; DMEM_CLEAR_EN adds a data-memory wipe after each load.
module cpu_mem_responder #(
    parameter int WIDTH      = 32,
    parameter int ADDRSIZE   = 12,
    parameter int IMEM_DEPTH = 4096,
    parameter int DMEM_DEPTH = 4096
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDRSIZE-1:0] MEM_ADDR,
    input  logic [0:WIDTH-1]    MEM_OUT,
    input  logic                MEM_CTRL,
    output logic [0:WIDTH-1]    MEM_IN,
    input  logic [ADDRSIZE-1:0] INS_ADDR,
    output logic [0:WIDTH-1]    INS_MEM,
    input  logic                ld_start,
    input  logic                ld_valid,
    input  logic [0:WIDTH-1]    ld_data,
    input  logic                ld_last,
    output logic                ld_ready,
    output logic [ADDRSIZE:0]   ld_count,
    output logic                cpu_rst,
    output logic                run
);

    localparam int IAW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
    localparam int DAW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;
    localparam logic [ADDRSIZE:0] IMEM_LIM = (ADDRSIZE+1)'(IMEM_DEPTH);
    localparam logic [ADDRSIZE:0] DMEM_LIM = (ADDRSIZE+1)'(DMEM_DEPTH);

`ifdef DMEM_CLEAR_EN
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_CLEAR} state_t;
    localparam logic [DAW-1:0] CLR_LAST = DAW'(DMEM_DEPTH - 1);
    logic [DAW-1:0] clr_q;
`else
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;
`endif

    state_t              state_q;
    logic                cpu_rst_q;
    logic                run_q;
    logic                ld_ready_q;
    logic [ADDRSIZE:0]   ld_count_q;
    logic [ADDRSIZE:0]   ld_count_d;
    logic                xfer;
    logic                load_done;
    logic                ins_ok;
    logic                mem_ok;

    logic [0:WIDTH-1]    imem [IMEM_DEPTH];
    logic [0:WIDTH-1]    dmem [DMEM_DEPTH];

    always_comb begin
        xfer       = ld_valid && ld_ready_q;
        ld_count_d = ld_count_q + (ADDRSIZE+1)'(1);
        // Filling the last implemented word ends the load even without ld_last.
        load_done  = ld_last || (ld_count_d == IMEM_LIM);
        ins_ok     = {1'b0, INS_ADDR} < IMEM_LIM;
        mem_ok     = {1'b0, MEM_ADDR} < DMEM_LIM;
    end

    assign INS_MEM  = ins_ok ? imem[INS_ADDR[IAW-1:0]] : '0;
    assign MEM_IN   = mem_ok ? dmem[MEM_ADDR[DAW-1:0]] : '0;
    assign ld_ready = ld_ready_q;
    assign ld_count = ld_count_q;
    assign cpu_rst  = cpu_rst_q;
    assign run      = run_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cpu_rst_q  <= 1'b1;
            run_q      <= 1'b0;
            ld_ready_q <= 1'b0;
            ld_count_q <= '0;
`ifdef DMEM_CLEAR_EN
            clr_q      <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ld_start) begin
                        state_q    <= S_LOAD;
                        ld_ready_q <= 1'b1;
                        ld_count_q <= '0;
                    end
                end
                S_LOAD: begin
                    if (xfer) begin
                        ld_count_q <= ld_count_d;
                        if (load_done) begin
                            ld_ready_q <= 1'b0;
`ifdef DMEM_CLEAR_EN
                            state_q    <= S_CLEAR;
                            clr_q      <= '0;
`else
                            state_q    <= S_RUN;
                            cpu_rst_q  <= 1'b0;
                            run_q      <= 1'b1;
`endif
                        end
                    end
                end
                S_RUN: begin
                    if (ld_start) begin
                        state_q    <= S_LOAD;
                        ld_ready_q <= 1'b1;
                        ld_count_q <= '0;
                        cpu_rst_q  <= 1'b1;
                        run_q      <= 1'b0;
                    end
                end
`ifdef DMEM_CLEAR_EN
                S_CLEAR: begin
                    if (clr_q == CLR_LAST) begin
                        state_q   <= S_RUN;
                        cpu_rst_q <= 1'b0;
                        run_q     <= 1'b1;
                    end else begin
                        clr_q <= clr_q + DAW'(1);
                    end
                end
`endif
                default: begin
                    state_q    <= S_IDLE;
                    cpu_rst_q  <= 1'b1;
                    run_q      <= 1'b0;
                    ld_ready_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (xfer) begin
            imem[ld_count_q[IAW-1:0]] <= ld_data;
        end
    end

    // Data memory commits on the falling edge so the CPU sees the value on its next rising edge.
    always_ff @(negedge clk) begin
`ifdef DMEM_CLEAR_EN
        if (state_q == S_CLEAR) begin
            dmem[clr_q] <= '0;
        end else
`endif
        if (MEM_CTRL && run_q && mem_ok) begin
            dmem[MEM_ADDR[DAW-1:0]] <= MEM_OUT;
        end
    end

endmodule
